// File: rtl/pipe_stage_reg_pkg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg_pkg
// Shared constants for the MIPS pipeline stage registers.
// Contents:
//   - NOP encoding loaded into a stage on a bubble
//   - default widths and multi-cycle latencies
//   - opcode/funct constants that decode logic uses to compute tnew_in and
//     mc_req before an instruction enters a stage register
//   - stage_op_e: the action a stage register takes on a clock edge
// ---------------------------------------------------------------------------
package pipe_stage_reg_pkg;

    // All-zero word (sll $0,$0,0) is the architectural NOP.
    localparam logic [31:0] NOP = 32'h0000_0000;

    localparam int DW_DEFAULT       = 32;
    localparam int TW_DEFAULT       = 3;
    localparam int MULT_LAT_DEFAULT = 5;
    localparam int DIV_LAT_DEFAULT  = 10;

    // The busy counter is 4 bits wide, so no latency may exceed 15.
    localparam int CNT_W = 4;

    // Primary opcodes (instr[31:26]).
    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_SW      = 6'b101011;

    // SPECIAL funct codes (instr[5:0]).
    localparam logic [5:0] FUNCT_JR    = 6'b001000;
    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;
    localparam logic [5:0] FUNCT_ADDU  = 6'b100001;
    localparam logic [5:0] FUNCT_SUBU  = 6'b100011;

    // What a stage register does on the next edge, in priority order.
    typedef enum logic [1:0] {
        STAGE_LOAD  = 2'd0,
        STAGE_HOLD  = 2'd1,
        STAGE_FLUSH = 2'd2
    } stage_op_e;

    // Helper for decode: is this a multiply/divide-class instruction?
    function automatic logic is_mc_op(input logic [31:0] instr);
        return (instr[31:26] == OP_SPECIAL) &&
               (instr[5:0] == FUNCT_MULT || instr[5:0] == FUNCT_MULTU ||
                instr[5:0] == FUNCT_DIV  || instr[5:0] == FUNCT_DIVU);
    endfunction

    // Helper for decode: selects the divide latency when is_mc_op is true.
    function automatic logic is_div_op(input logic [31:0] instr);
        return (instr[31:26] == OP_SPECIAL) &&
               (instr[5:0] == FUNCT_DIV || instr[5:0] == FUNCT_DIVU);
    endfunction

endpackage

// File: rtl/pipe_stage_reg_mc_busy_counter.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg_mc_busy_counter
// Occupancy counter for the multiply/divide unit. A start pulse loads the
// selected latency, then the count falls by one per cycle until it reaches
// zero. busy is high while the count is nonzero, so it stays high for
// exactly the loaded number of cycles.
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous, active-low clear
//   start  in   load a new latency this edge (restarts if already busy)
//   div    in   with start: 1 = DIV_LAT, 0 = MULT_LAT
//   cnt    out  remaining busy cycles
//   busy   out  cnt != 0
// ---------------------------------------------------------------------------
module pipe_stage_reg_mc_busy_counter #(
    parameter int CW       = 4,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          div,
    output logic [CW-1:0] cnt,
    output logic          busy
);

    localparam int MAX_LAT = (1 << CW) - 1;

    // A latency wider than the counter would silently truncate.
    if (MULT_LAT > MAX_LAT || DIV_LAT > MAX_LAT || MULT_LAT < 1 || DIV_LAT < 1) begin : g_lat_check
        $error("mc_busy_counter: latencies must be in 1..%0d", MAX_LAT);
    end

    localparam logic [CW-1:0] MULT_CNT = CW'(MULT_LAT);
    localparam logic [CW-1:0] DIV_CNT  = CW'(DIV_LAT);

    // The unit runs independently of the stage contents, so the count keeps
    // falling through hold and flush; only start or reset override it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= div ? DIV_CNT : MULT_CNT;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign busy = (cnt != '0);

endmodule

// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
// Reusable inter-stage pipeline register (D/E, E/M, M/W) for the five-stage
// MIPS core. Carries instruction, PC, LANES payload words and Tnew, with
// hold (stall), flush (bubble) and a multi-cycle busy counter.
// Priority per edge: flush > hold > load.
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-low clear of all state
//   hold       in   keep current contents
//   flush      in   load a bubble (PC still captured)
//   instr_in   in   instruction from upstream
//   pc_in      in   PC from upstream
//   lane_in    in   packed payload, lane 0 in the LSBs
//   tnew_in    in   Tnew from upstream decode
//   mc_req     in   upstream instruction is multiply/divide class
//   mc_div     in   with mc_req: divide latency instead of multiply
//   instr_q    out  registered instruction
//   pc_q       out  registered PC
//   lane_q     out  registered payload
//   tnew_q     out  registered Tnew
//   tnew_next  out  saturating tnew_q - 1 for the next stage
//   valid_q    out  stage holds a real (non-NOP) instruction
//   busy       out  multiply/divide unit occupied
//   busy_cnt   out  remaining busy cycles
// ---------------------------------------------------------------------------
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int DW       = DW_DEFAULT,
    parameter int LANES    = 3,
    parameter int TW       = TW_DEFAULT,
    parameter int MULT_LAT = MULT_LAT_DEFAULT,
    parameter int DIV_LAT  = DIV_LAT_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                hold,
    input  logic                flush,
    input  logic [DW-1:0]       instr_in,
    input  logic [DW-1:0]       pc_in,
    input  logic [LANES*DW-1:0] lane_in,
    input  logic [TW-1:0]       tnew_in,
    input  logic                mc_req,
    input  logic                mc_div,
    output logic [DW-1:0]       instr_q,
    output logic [DW-1:0]       pc_q,
    output logic [LANES*DW-1:0] lane_q,
    output logic [TW-1:0]       tnew_q,
    output logic [TW-1:0]       tnew_next,
    output logic                valid_q,
    output logic                busy,
    output logic [CNT_W-1:0]    busy_cnt
);

    localparam logic [DW-1:0] NOP_W = DW'(NOP);

    stage_op_e op;

    // Resolve flush > hold > load once so every register agrees on it.
    always_comb begin
        op = STAGE_LOAD;
        if (flush) begin
            op = STAGE_FLUSH;
        end else if (hold) begin
            op = STAGE_HOLD;
        end
    end

    // Control fields. A bubble keeps pc_in so a later exception can still
    // report the PC of the squashed slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_q <= '0;
            pc_q    <= '0;
            tnew_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            case (op)
                STAGE_FLUSH: begin
                    instr_q <= NOP_W;
                    pc_q    <= pc_in;
                    tnew_q  <= '0;
                    valid_q <= 1'b0;
                end
                STAGE_HOLD: begin
                    instr_q <= instr_q;
                    pc_q    <= pc_q;
                    tnew_q  <= tnew_q;
                    valid_q <= valid_q;
                end
                default: begin
                    instr_q <= instr_in;
                    pc_q    <= pc_in;
                    tnew_q  <= tnew_in;
                    valid_q <= (instr_in != NOP_W);
                end
            endcase
        end
    end

    // Payload lanes: one plain register per lane, zeroed on a bubble.
    logic [DW-1:0] lane_r [LANES];

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                lane_r[g] <= '0;
            end else if (op == STAGE_FLUSH) begin
                lane_r[g] <= '0;
            end else if (op == STAGE_LOAD) begin
                lane_r[g] <= lane_in[g*DW +: DW];
            end
        end
    end

    // Repack the lane registers into the flat output bus.
    always_comb begin
        lane_q = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_q[i*DW +: DW] = lane_r[i];
        end
    end

    // Tnew saturates at zero so a finished producer never wraps back to
    // looking like a far-future one.
    assign tnew_next = (tnew_q == '0) ? '0 : tnew_q - 1'b1;

    // mc_req only counts when the stage actually loads the instruction.
    pipe_stage_reg_mc_busy_counter #(
        .CW       (CNT_W),
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT)
    ) u_mc_busy_counter (
        .clk   (clk),
        .reset (reset),
        .start (op == STAGE_LOAD && mc_req),
        .div   (mc_div),
        .cnt   (busy_cnt),
        .busy  (busy)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_reg
// Self-checking bench for pipe_stage_reg with default parameters.
// A behavioural model tracks the expected stage contents and the remaining
// multi-cycle time; a compare process checks the DUT against it on every
// falling edge, and directed vectors pin key values with literals.
// ---------------------------------------------------------------------------
module tb_pipe_stage_reg;

    logic        clk;
    logic        reset;
    logic        hold;
    logic        flush;
    logic [31:0] instr_in;
    logic [31:0] pc_in;
    logic [95:0] lane_in;
    logic [2:0]  tnew_in;
    logic        mc_req;
    logic        mc_div;
    logic [31:0] instr_q;
    logic [31:0] pc_q;
    logic [95:0] lane_q;
    logic [2:0]  tnew_q;
    logic [2:0]  tnew_next;
    logic        valid_q;
    logic        busy;
    logic [3:0]  busy_cnt;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 0;

    pipe_stage_reg dut (
        .clk       (clk),
        .reset     (reset),
        .hold      (hold),
        .flush     (flush),
        .instr_in  (instr_in),
        .pc_in     (pc_in),
        .lane_in   (lane_in),
        .tnew_in   (tnew_in),
        .mc_req    (mc_req),
        .mc_div    (mc_div),
        .instr_q   (instr_q),
        .pc_q      (pc_q),
        .lane_q    (lane_q),
        .tnew_q    (tnew_q),
        .tnew_next (tnew_next),
        .valid_q   (valid_q),
        .busy      (busy),
        .busy_cnt  (busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: expected contents and remaining busy time as ints.
    logic [31:0] m_instr = '0;
    logic [31:0] m_pc    = '0;
    logic [95:0] m_lane  = '0;
    int          m_tnew  = 0;
    bit          m_valid = 0;
    int          m_left  = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_instr <= '0;
            m_pc    <= '0;
            m_lane  <= '0;
            m_tnew  <= 0;
            m_valid <= 0;
            m_left  <= 0;
        end else begin
            if (flush) begin
                m_instr <= '0;
                m_pc    <= pc_in;
                m_lane  <= '0;
                m_tnew  <= 0;
                m_valid <= 0;
            end else if (!hold) begin
                m_instr <= instr_in;
                m_pc    <= pc_in;
                m_lane  <= lane_in;
                m_tnew  <= int'(tnew_in);
                m_valid <= (instr_in != 32'h0);
            end
            if (!flush && !hold && mc_req)
                m_left <= mc_div ? 10 : 5;
            else if (m_left > 0)
                m_left <= m_left - 1;
        end
    end

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Continuous comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            checkOutput("cmp_instr_q", instr_q, m_instr);
            checkOutput("cmp_pc_q", pc_q, m_pc);
            checkOutput("cmp_lane_q", lane_q, m_lane);
            checkOutput("cmp_tnew_q", tnew_q, m_tnew);
            checkOutput("cmp_tnew_next", tnew_next, (m_tnew == 0) ? 0 : m_tnew - 1);
            checkOutput("cmp_valid_q", valid_q, m_valid);
            checkOutput("cmp_busy", busy, m_left != 0);
            checkOutput("cmp_busy_cnt", busy_cnt, m_left);
        end
    end

    // Drive one cycle of inputs, then return 1 time unit after the edge.
    task automatic applyStimulus(input bit h, input bit f, input logic [31:0] instr,
                                 input logic [31:0] pc, input logic [31:0] l0,
                                 input logic [31:0] l1, input logic [31:0] l2,
                                 input logic [2:0] tn, input bit req, input bit dv);
        hold     = h;
        flush    = f;
        instr_in = instr;
        pc_in    = pc;
        lane_in  = {l2, l1, l0};
        tnew_in  = tn;
        mc_req   = req;
        mc_div   = dv;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(0, 0, 32'h0, 32'h3100, 0, 0, 0, 3'd0, 0, 0);
    endtask

    int busy_len;

    initial begin
        reset = 1'b1;
        hold = 0; flush = 0; instr_in = '0; pc_in = '0; lane_in = '0;
        tnew_in = '0; mc_req = 0; mc_div = 0;
        #2 reset = 1'b0;
        cmp_en = 1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_instr_q", instr_q, 32'h0);
        checkOutput("reset_valid_q", valid_q, 1'b0);
        checkOutput("reset_busy_cnt", busy_cnt, 4'd0);
        reset = 1'b1;

        // Basic load.
        applyStimulus(0, 0, 32'h0232_8020, 32'h3000, 5, 7, 9, 3'd1, 0, 0);
        checkOutput("load_instr_q", instr_q, 32'h0232_8020);
        checkOutput("load_pc_q", pc_q, 32'h3000);
        checkOutput("load_lane_q", lane_q, {32'd9, 32'd7, 32'd5});
        checkOutput("load_valid_q", valid_q, 1'b1);
        checkOutput("load_tnew_next", tnew_next, 3'd0);

        // Hold for three cycles with changing inputs.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 0, 32'h1111_1111 * (i + 1), 32'h4000 + i, i, i, i, 3'd5, 1, 0);
            checkOutput("hold_instr_q", instr_q, 32'h0232_8020);
            checkOutput("hold_pc_q", pc_q, 32'h3000);
            checkOutput("hold_busy", busy, 1'b0);
        end
        applyStimulus(0, 0, 32'h8C08_0004, 32'h3004, 1, 2, 3, 3'd2, 0, 0);
        checkOutput("release_instr_q", instr_q, 32'h8C08_0004);
        checkOutput("release_tnew_next", tnew_next, 3'd1);

        // Flush together with hold acts as a bubble that keeps pc_in.
        applyStimulus(1, 1, 32'hDEAD_BEEF, 32'h3008, 4, 4, 4, 3'd3, 0, 0);
        checkOutput("flush_instr_q", instr_q, 32'h0);
        checkOutput("flush_lane_q", lane_q, 96'h0);
        checkOutput("flush_valid_q", valid_q, 1'b0);
        checkOutput("flush_tnew_q", tnew_q, 3'd0);
        checkOutput("flush_pc_q", pc_q, 32'h3008);

        // Loading a NOP leaves the stage invalid.
        applyStimulus(0, 0, 32'h0, 32'h300C, 1, 1, 1, 3'd0, 0, 0);
        checkOutput("nop_valid_q", valid_q, 1'b0);
        checkOutput("nop_pc_q", pc_q, 32'h300C);

        // Multiply: busy for exactly 5 cycles.
        busy_len = 0;
        applyStimulus(0, 0, 32'h0085_0018, 32'h3010, 0, 0, 0, 3'd0, 1, 0);
        checkOutput("mult_busy_cnt", busy_cnt, 4'd5);
        for (int i = 0; i < 30 && busy; i++) begin
            busy_len++;
            idle();
        end
        checkOutput("mult_busy_len", busy_len, 5);

        // Divide with a flush in its second cycle: still 10 cycles.
        busy_len = 0;
        applyStimulus(0, 0, 32'h0085_001A, 32'h3014, 0, 0, 0, 3'd0, 1, 1);
        checkOutput("div_busy_cnt", busy_cnt, 4'd10);
        for (int i = 0; i < 30 && busy; i++) begin
            busy_len++;
            if (i == 0)
                applyStimulus(0, 1, 32'h0, 32'h3018, 0, 0, 0, 3'd0, 1, 0);
            else
                idle();
        end
        checkOutput("div_flush_busy_len", busy_len, 10);

        // Asynchronous reset while six cycles remain.
        applyStimulus(0, 0, 32'h0085_001A, 32'h3020, 0, 0, 0, 3'd0, 1, 1);
        repeat (3) idle();
        applyStimulus(0, 0, 32'h2442_0001, 32'h3200, 1, 1, 1, 3'd3, 0, 0);
        checkOutput("pre_reset_busy_cnt", busy_cnt, 4'd6);
        #2 reset = 1'b0;
        #1;
        checkOutput("async_instr_q", instr_q, 32'h0);
        checkOutput("async_pc_q", pc_q, 32'h0);
        checkOutput("async_lane_q", lane_q, 96'h0);
        checkOutput("async_tnew_q", tnew_q, 3'd0);
        checkOutput("async_valid_q", valid_q, 1'b0);
        checkOutput("async_busy", busy, 1'b0);
        checkOutput("async_busy_cnt", busy_cnt, 4'd0);
        #1 reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idle();
            checkOutput("post_reset_busy", busy, 1'b0);
        end

        // Tnew saturation.
        applyStimulus(0, 0, 32'h3C01_1234, 32'h3300, 0, 0, 0, 3'd0, 0, 0);
        checkOutput("tnew0_next", tnew_next, 3'd0);
        applyStimulus(0, 0, 32'h3C01_1234, 32'h3304, 0, 0, 0, 3'd7, 0, 0);
        checkOutput("tnew7_next", tnew_next, 3'd6);
        applyStimulus(0, 0, 32'h3C01_1234, 32'h3308, 0, 0, 0, 3'd2, 0, 0);
        checkOutput("tnew2_next", tnew_next, 3'd1);

        @(negedge clk);
        cmp_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
